// File: rtl/systolic_mm_tile.sv
// Output-stationary systolic matrix-multiply tile: C = A * B over an inner dimension K,
// with A/B fetched from 1-cycle-latency buffers and C streamed one row per valid/ready beat.
module systolic_mm_tile #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           K,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic                 A_rd_en,
    output logic [15:0]          A_index,
    input  logic [ROWS*DW-1:0]   A_data_out,
    output logic                 B_rd_en,
    output logic [15:0]          B_index,
    input  logic [COLS*DW-1:0]   B_data_out,
    output logic                 C_valid,
    input  logic                 C_ready,
    output logic [15:0]          C_index,
    output logic [COLS*ACCW-1:0] C_data
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = 2 * DW + 2;

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            k_q;
    logic                  sm_q;
    logic [15:0]           idx_q;
    logic                  rd_vld_q;
    logic [RW-1:0]         r_q;
    logic [COLS*ACCW-1:0]  c_data_q;
    logic                  done_q;

    logic                  accept, rd_en, compute_end, beat, last_beat;
    logic [RW-1:0]         ld_row;
    logic [COLS*ACCW-1:0]  row_vec;

    logic [DW-1:0]         a_raw [ROWS];
    logic [DW-1:0]         a_sk  [ROWS];
    logic [DW-1:0]         b_raw [COLS];
    logic [DW-1:0]         b_sk  [COLS];
    logic [DW-1:0]         a_in    [ROWS][COLS];
    logic [DW-1:0]         b_in    [ROWS][COLS];
    logic [DW-1:0]         a_fwd_q [ROWS][COLS];
    logic [DW-1:0]         b_fwd_q [ROWS][COLS];
    logic [ACCW-1:0]       acc_q   [ROWS][COLS];

    // Operands are widened by two bits so one signed multiply covers both modes.
    function automatic logic [ACCW-1:0] ext_prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic sm);
        logic signed [PW-1:0] ea, eb, p;
        ea = {{(DW+2){sm & a[DW-1]}}, a};
        eb = {{(DW+2){sm & b[DW-1]}}, b};
        p  = ea * eb;
        return ACCW'(p);
    endfunction

    assign accept      = (state_q == IDLE) && in_valid;
    assign rd_en       = (state_q == COMPUTE) && (cnt_q < {8'd0, k_q});
    assign compute_end = (state_q == COMPUTE) && (cnt_q == {8'd0, k_q} + 16'(ROWS + COLS - 1));
    assign beat        = (state_q == DRAIN) && C_ready;
    assign last_beat   = beat && (r_q == RW'(ROWS - 1));
    assign ld_row      = compute_end ? '0 : r_q + RW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (in_valid) begin
                         state_d = COMPUTE;
                         cnt_d   = '0;
                     end
            COMPUTE: if (compute_end) state_d = DRAIN;
                     else cnt_d = cnt_q + 16'd1;
            DRAIN:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_vec = '0;
        for (int j = 0; j < COLS; j++)
            row_vec[(COLS-1-j)*ACCW +: ACCW] = acc_q[ld_row][j];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            sm_q     <= 1'b0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
            r_q      <= '0;
            c_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= last_beat;
            rd_vld_q <= rd_en;
            if (accept) begin
                k_q  <= K;
                sm_q <= signed_mode;
            end
            if (rd_en) idx_q <= cnt_q;
            if (compute_end) begin
                r_q      <= '0;
                c_data_q <= row_vec;
            end else if (beat && !last_beat) begin
                r_q      <= r_q + RW'(1);
                c_data_q <= row_vec;
            end
        end
    end

    // Idle cycles feed zeros so the array can keep clocking without corrupting sums.
    always_comb begin
        for (int i = 0; i < ROWS; i++)
            a_raw[i] = rd_vld_q ? A_data_out[(ROWS-1-i)*DW +: DW] : '0;
        for (int j = 0; j < COLS; j++)
            b_raw[j] = rd_vld_q ? B_data_out[(COLS-1-j)*DW +: DW] : '0;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        if (i == 0) begin : g_direct
            assign a_sk[i] = a_raw[i];
        end else begin : g_delay
            logic [DW-1:0] sh_q [i];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int d = 0; d < i; d++) sh_q[d] <= '0;
                end else begin
                    sh_q[0] <= a_raw[i];
                    for (int d = 1; d < i; d++) sh_q[d] <= sh_q[d-1];
                end
            end
            assign a_sk[i] = sh_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        if (j == 0) begin : g_direct
            assign b_sk[j] = b_raw[j];
        end else begin : g_delay
            logic [DW-1:0] sh_q [j];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int d = 0; d < j; d++) sh_q[d] <= '0;
                end else begin
                    sh_q[0] <= b_raw[j];
                    for (int d = 1; d < j; d++) sh_q[d] <= sh_q[d-1];
                end
            end
            assign b_sk[j] = sh_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            if (j == 0) begin : g_al
                assign a_in[i][j] = a_sk[i];
            end else begin : g_af
                assign a_in[i][j] = a_fwd_q[i][j-1];
            end
            if (i == 0) begin : g_bt
                assign b_in[i][j] = b_sk[j];
            end else begin : g_bf
                assign b_in[i][j] = b_fwd_q[i-1][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_fwd_q[i][j] <= '0;
                    b_fwd_q[i][j] <= '0;
                    acc_q[i][j]   <= '0;
                end
        end else begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_fwd_q[i][j] <= a_in[i][j];
                    b_fwd_q[i][j] <= b_in[i][j];
                    if (accept)
                        acc_q[i][j] <= '0;
                    else if (state_q == COMPUTE)
                        acc_q[i][j] <= acc_q[i][j] + ext_prod(a_in[i][j], b_in[i][j], sm_q);
                end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign A_rd_en = rd_en;
    assign B_rd_en = rd_en;
    assign A_index = rd_en ? cnt_q : idx_q;
    assign B_index = rd_en ? cnt_q : idx_q;
    assign C_valid = (state_q == DRAIN);
    assign C_index = 16'(r_q);
    assign C_data  = c_data_q;
endmodule

// File: tb/tb_systolic_mm_tile.sv
// Directed bench for systolic_mm_tile: a 32-bit accumulator instance and a 16-bit one
// share stimulus and buffer models; expected C tiles are hand-computed per job.
module tb_systolic_mm_tile;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, signed_mode, C_ready;
    logic [7:0]   K;
    logic         busy, done, A_rd_en, B_rd_en, C_valid;
    logic [15:0]  A_index, B_index, C_index;
    logic [31:0]  A_data_out, B_data_out;
    logic [127:0] C_data;
    logic         busy_w, done_w, a_rd_w, b_rd_w, cv_w;
    logic [15:0]  a_idx_w, b_idx_w, ci_w;
    logic [63:0]  cd_w;

    logic [31:0]  amem [16];
    logic [31:0]  bmem [16];
    logic [31:0]  expc [4][4];
    logic [15:0]  expw [4][4];
    int           rdcnt = 0;
    int           snap;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    systolic_mm_tile #(.ROWS(4), .COLS(4), .DW(8), .ACCW(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .signed_mode(signed_mode),
        .busy(busy), .done(done), .A_rd_en(A_rd_en), .A_index(A_index), .A_data_out(A_data_out),
        .B_rd_en(B_rd_en), .B_index(B_index), .B_data_out(B_data_out), .C_valid(C_valid),
        .C_ready(C_ready), .C_index(C_index), .C_data(C_data));

    systolic_mm_tile #(.ROWS(4), .COLS(4), .DW(8), .ACCW(16)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .signed_mode(signed_mode),
        .busy(busy_w), .done(done_w), .A_rd_en(a_rd_w), .A_index(a_idx_w), .A_data_out(A_data_out),
        .B_rd_en(b_rd_w), .B_index(b_idx_w), .B_data_out(B_data_out), .C_valid(cv_w),
        .C_ready(C_ready), .C_index(ci_w), .C_data(cd_w));

    // Synchronous-read buffer models (1-cycle latency).
    always @(posedge clk) begin
        if (A_rd_en) A_data_out <= amem[A_index[3:0]];
        if (B_rd_en) B_data_out <= bmem[B_index[3:0]];
        if (A_rd_en) rdcnt <= rdcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit rdy(input int d);
        if (d >= 1 && d <= 5) return 1'b0;
        if (d <= 6) return 1'b1;
        return (d % 2) == 0;
    endfunction

    task automatic set_exp(input logic [31:0] v, input logic [15:0] w);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expc[r][c] = v;
                expw[r][c] = w;
            end
    endtask

    task automatic fill_ff();
        for (int k = 0; k < 16; k++) begin
            amem[k] = 32'hFFFF_FFFF;
            bmem[k] = 32'hFFFF_FFFF;
        end
    endtask

    // A = identity, B[k][j] = 4k+j+1, so C = B.
    task automatic fill_identity();
        for (int k = 0; k < 16; k++) begin
            amem[k] = (k < 4) ? (32'hFF00_0000 >> (8 * k)) & (32'h0100_0000 >> (8 * k)) : 32'h0;
            bmem[k] = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expc[r][c] = 32'(4*r + c + 1);
                expw[r][c] = 16'(4*r + c + 1);
            end
    endtask

    task automatic start_job(input logic [7:0] k, input logic sm);
        in_valid = 1'b1;
        K = k;
        signed_mode = sm;
        step();
        in_valid = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic collect(input string tag, input int n0, input int first, input bit bp);
        int n, r, d;
        n = n0;
        while (C_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_first_valid"}, 64'(n), 64'(first));
        r = 0;
        d = 0;
        while (r < 4 && d < 40) begin
            C_ready = bp ? rdy(d) : 1'b1;
            chk({tag, "_valid"}, 64'(C_valid), 64'd1);
            chk({tag, "_wvalid"}, 64'(cv_w), 64'd1);
            chk({tag, "_index"}, 64'(C_index), 64'(r));
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_data"}, 64'(C_data[(3-c)*32 +: 32]), 64'(expc[r][c]));
                chk({tag, "_wdata"}, 64'(cd_w[(3-c)*16 +: 16]), 64'(expw[r][c]));
            end
            if (C_ready) r++;
            step();
            d++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_valid_low"}, 64'(C_valid), 64'd0);
        C_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        K = 8'd0;
        signed_mode = 1'b0;
        C_ready = 1'b1;
        fill_identity();
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cvalid", 64'(C_valid), 64'd0);
        chk("rst_cindex", 64'(C_index), 64'd0);
        chk("rst_cdata", C_data[63:0], 64'd0);
        chk("rst_ardEn", 64'(A_rd_en), 64'd0);
        chk("rst_brdEn", 64'(B_rd_en), 64'd0);
        chk("rst_aindex", 64'(A_index), 64'd0);
        rst_n = 1'b1;
        step();

        // Identity job with read-strobe / index trace.
        snap = rdcnt;
        start_job(8'd4, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            chk("id_ard", 64'(A_rd_en), (n <= 4) ? 64'd1 : 64'd0);
            chk("id_brd", 64'(B_rd_en), (n <= 4) ? 64'd1 : 64'd0);
            chk("id_aidx", 64'(A_index), (n <= 4) ? 64'(n - 1) : 64'd3);
            chk("id_bidx", 64'(B_index), (n <= 4) ? 64'(n - 1) : 64'd3);
            step();
        end
        collect("ident", 6, 13, 1'b0);
        chk("ident_reads", 64'(rdcnt - snap), 64'd4);

        // All -1 signed, K=3: each C = 3. Starts in the done cycle.
        fill_ff();
        set_exp(32'd3, 16'd3);
        start_job(8'd3, 1'b1);
        collect("signed", 1, 12, 1'b0);

        // Same data unsigned: 3*255*255 = 195075; 16-bit wrap 195075-131072 = 64003.
        set_exp(32'd195075, 16'd64003);
        start_job(8'd3, 1'b0);
        collect("unsigned", 1, 12, 1'b0);

        // K=2 unsigned: 130050, 16-bit wrap 64514.
        set_exp(32'd130050, 16'd64514);
        start_job(8'd2, 1'b0);
        collect("wrap", 1, 11, 1'b0);

        // K=0: no reads, zero tile, first beat at T+9.
        set_exp(32'd0, 16'd0);
        snap = rdcnt;
        start_job(8'd0, 1'b0);
        chk("k0_nord", 64'(A_rd_en), 64'd0);
        collect("k0", 1, 9, 1'b0);
        chk("k0_reads", 64'(rdcnt - snap), 64'd0);

        // Backpressure: A[i][k] = i+1, B[k][j] = 4k+j+1 -> C[r][c] = (r+1)*(28+4c).
        fill_identity();
        for (int k = 0; k < 4; k++) amem[k] = 32'h0102_0304;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expc[r][c] = 32'((r + 1) * (28 + 4 * c));
                expw[r][c] = 16'((r + 1) * (28 + 4 * c));
            end
        start_job(8'd4, 1'b0);
        collect("bp", 1, 13, 1'b1);

        // Start request while busy must be ignored.
        fill_identity();
        start_job(8'd4, 1'b0);
        step();
        in_valid = 1'b1;
        K = 8'd0;
        signed_mode = 1'b1;
        step();
        in_valid = 1'b0;
        K = 8'd4;
        signed_mode = 1'b0;
        collect("ignored", 3, 13, 1'b0);

        // Reset in the middle of COMPUTE.
        start_job(8'd4, 1'b0);
        for (int n = 0; n < 5; n++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_cindex", 64'(C_index), 64'd0);
        chk("mrst_cdata", C_data[127:64], 64'd0);
        chk("mrst_aindex", 64'(A_index), 64'd0);
        for (int n = 0; n < 10; n++) begin
            chk("mrst_no_done", 64'(done), 64'd0);
            chk("mrst_no_valid", 64'(C_valid), 64'd0);
            step();
        end

        fill_ff();
        set_exp(32'd3, 16'd3);
        start_job(8'd3, 1'b1);
        collect("post_rst", 1, 12, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
